// File: rtl/lock_code_sender.sv
// Combination-lock code sender: replays a latched code as b0/b1 press pulses, then watches unlock.
// Optional build macro LOCK_SENDER_PREAMBLE_EN prepends three b1 presses that reset the lock.
module lock_code_sender #(
    parameter int MAX_LEN      = 8,
    parameter int GAP_CYCLES   = 2,
    parameter int CHECK_CYCLES = 4,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [MAX_LEN-1:0] code,
    input  logic [LW-1:0]      code_len,
    input  logic               unlock,
    output logic               b0,
    output logic               b1,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [LW-1:0]      sym_idx
);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int CW = $clog2(CHECK_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CHK_LAST = CW'(CHECK_CYCLES - 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        PRESS = 3'd2,
        GAP   = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5
    } state_t;

    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
        return (len > LEN_MAX) ? LEN_MAX : len;
    endfunction

    state_t             state_r;
    logic [MAX_LEN-1:0] code_r;
    logic [LW-1:0]      len_r;
    logic [GW-1:0]      gap_cnt_r;
    logic [CW-1:0]      chk_cnt_r;
`ifdef LOCK_SENDER_PREAMBLE_EN
    logic [1:0]         pre_cnt_r;
`endif
    logic [LW-1:0]      len_s;
    logic               last_sym_s;

    assign len_s      = clamp_len(code_len);
    assign last_sym_s = ((sym_idx + LW'(1)) == len_r);

    // Sequencer: code_r shifts right so the next symbol to send is always code_r[0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            code_r    <= '0;
            len_r     <= '0;
            gap_cnt_r <= '0;
            chk_cnt_r <= '0;
`ifdef LOCK_SENDER_PREAMBLE_EN
            pre_cnt_r <= 2'd0;
`endif
            b0        <= 1'b0;
            b1        <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            sym_idx   <= '0;
        end else begin
            b0   <= 1'b0;
            b1   <= 1'b0;
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        len_r     <= len_s;
                        pass      <= 1'b0;
                        sym_idx   <= '0;
                        busy      <= 1'b1;
                        chk_cnt_r <= '0;
`ifdef LOCK_SENDER_PREAMBLE_EN
                        code_r    <= code;
                        pre_cnt_r <= 2'd0;
                        b1        <= 1'b1;
                        state_r   <= PRE;
`else
                        if (len_s == '0) begin
                            code_r  <= code;
                            state_r <= CHECK;
                        end else begin
                            b0      <= ~code[0];
                            b1      <= code[0];
                            code_r  <= code >> 1'b1;
                            state_r <= PRESS;
                        end
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
`ifdef LOCK_SENDER_PREAMBLE_EN
                // b1 still high marks the press cycle of the current preamble press.
                PRE: begin
                    if (b1) begin
                        if ((pre_cnt_r == 2'd2) && (len_r == '0)) begin
                            chk_cnt_r <= '0;
                            state_r   <= CHECK;
                        end else begin
                            gap_cnt_r <= GAP_LAST;
                        end
                    end else if (gap_cnt_r != '0) begin
                        gap_cnt_r <= gap_cnt_r - 1'b1;
                    end else if (pre_cnt_r == 2'd2) begin
                        b0      <= ~code_r[0];
                        b1      <= code_r[0];
                        code_r  <= code_r >> 1'b1;
                        state_r <= PRESS;
                    end else begin
                        pre_cnt_r <= pre_cnt_r + 2'd1;
                        b1        <= 1'b1;
                    end
                end
`endif
                PRESS: begin
                    gap_cnt_r <= GAP_LAST;
                    chk_cnt_r <= '0;
                    state_r   <= last_sym_s ? CHECK : GAP;
                end
                GAP: begin
                    if (gap_cnt_r != '0) begin
                        gap_cnt_r <= gap_cnt_r - 1'b1;
                    end else begin
                        sym_idx <= sym_idx + LW'(1);
                        b0      <= ~code_r[0];
                        b1      <= code_r[0];
                        code_r  <= code_r >> 1'b1;
                        state_r <= PRESS;
                    end
                end
                CHECK: begin
                    if (unlock) begin
                        pass    <= 1'b1;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= DONE;
                    end else if (chk_cnt_r == CHK_LAST) begin
                        pass    <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= DONE;
                    end else begin
                        chk_cnt_r <= chk_cnt_r + 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_code_sender.sv
// Scoreboard bench for lock_code_sender: expected presses and results are queued at each start.
module tb_lock_code_sender;
    localparam int GAP = 2;
    localparam int CHK = 4;
`ifdef LOCK_SENDER_PREAMBLE_EN
    localparam int NPRE = 3;
`else
    localparam int NPRE = 0;
`endif

    typedef struct {int cyc; int btn;} press_t;
    typedef struct {int cyc; int pass; int idx;} res_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] code;
    logic [3:0] code_len;
    logic       unlock;
    logic       b0, b1, busy, done, pass;
    logic [3:0] sym_idx;

    press_t pq[$];
    res_t   rq[$];
    int     cyc;
    int     n_cmp;
    int     n_bad;
    int     exp_pass;

    lock_code_sender #(.MAX_LEN(8), .GAP_CYCLES(GAP), .CHECK_CYCLES(CHK)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .code(code), .code_len(code_len),
        .unlock(unlock), .b0(b0), .b1(b1), .busy(busy), .done(done), .pass(pass),
        .sym_idx(sym_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a press or a done pulse.
    initial begin
        press_t p;
        res_t   q;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (b0 || b1) begin
                    check("one_button", int'(b0 && b1), 0);
                    if (pq.size() == 0) begin
                        check("unexpected_press", 1, 0);
                    end else begin
                        p = pq.pop_front();
                        check("press_cycle", cyc, p.cyc);
                        check("press_button", int'(b1), p.btn);
                    end
                end
                if (done) begin
                    if (rq.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        q = rq.pop_front();
                        check("done_cycle", cyc, q.cyc);
                        check("pass", int'(pass), q.pass);
                        check("sym_idx", int'(sym_idx), q.idx);
                        check("done_busy", int'(busy), 0);
                    end
                end
            end
        end
    end

    // One transaction: k = index of the first check sample at which unlock is high (CHK = never).
    task automatic run_txn(input logic [7:0] c, input logic [3:0] l, input int k, input int abort_at);
        int     n, tot, last, dr, t0;
        press_t p;
        res_t   q;
        @(negedge clk);
        t0 = cyc;
        check("pass_hold", int'(pass), exp_pass);
        check("idle_busy", int'(busy), 0);
        n    = (l > 4'd8) ? 8 : int'(l);
        tot  = NPRE + n;
        last = (tot > 0) ? tot * (GAP + 1) - GAP : 0;
        dr   = (k < CHK) ? last + 2 + k : last + CHK + 1;
        for (int i = 0; i < tot; i++) begin
            p.cyc = t0 + 1 + i * (GAP + 1);
            p.btn = (i < NPRE) ? 1 : int'((c >> (i - NPRE)) & 8'd1);
            pq.push_back(p);
        end
        q.cyc  = t0 + dr;
        q.pass = (k < CHK) ? 1 : 0;
        q.idx  = (n > 0) ? n - 1 : 0;
        rq.push_back(q);
        exp_pass = q.pass;
        start    = 1'b1;
        code     = c;
        code_len = l;
        unlock   = 1'($urandom_range(0, 1));
        for (int r = 1; r <= dr; r++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 3) == 0);
            code     = 8'($urandom);
            code_len = 4'($urandom);
            if (r <= last) unlock = 1'($urandom_range(0, 1));
            else           unlock = (r >= last + 1 + k);
            check("busy", int'(busy), (r < dr) ? 1 : 0);
            if (r == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                check("rst_b0", int'(b0), 0);
                check("rst_b1", int'(b1), 0);
                check("rst_busy", int'(busy), 0);
                check("rst_pass", int'(pass), 0);
                check("rst_done", int'(done), 0);
                pq.delete();
                rq.delete();
                exp_pass = 0;
                start    = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
        end
        start  = 1'b0;
        unlock = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        exp_pass = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        code     = 8'h00;
        code_len = 4'd0;
        unlock   = 1'b0;
        #12;
        check("reset_b0", int'(b0), 0);
        check("reset_b1", int'(b1), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_pass", int'(pass), 0);
        check("reset_sym_idx", int'(sym_idx), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_txn(8'h1A, 4'd5, 0, 0);
        run_txn(8'h0A, 4'd5, CHK, 0);
        run_txn(8'h3C, 4'd0, 2, 0);
        run_txn(8'h1A, 4'd5, 0, 7);
        run_txn(8'h1A, 4'd5, 0, 0);
        run_txn(8'hA5, 4'd15, 2, 0);
        run_txn(8'hFF, 4'd1, CHK - 1, 0);
        for (int t = 0; t < 40; t++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                unlock = 1'($urandom_range(0, 1));
            end
            run_txn(8'($urandom), 4'($urandom_range(0, 15)), $urandom_range(0, CHK), 0);
        end

        repeat (6) @(negedge clk);
        check("presses_outstanding", pq.size(), 0);
        check("results_outstanding", rq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
